// File: rtl/rv32_e_div_seq_pkg.sv
// Shared types and constants for the RV32M sequential divider.
package rv32_e_div_seq_pkg;

    // Default operand/result width; the iteration count equals this width.
    localparam int XLEN_DFLT = 32;

    // Operation encoding as decoded from funct3 by the execute stage.
    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/rv32_e_div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Operates on magnitudes, then applies signs in a dedicated fix-up cycle.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module rv32_e_div_seq
    import rv32_e_div_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DFLT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);

    div_state_e        state_q, state_d;
    div_op_e           op_q, op_d;
    logic              sgn_q, sgn_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand conditioning for a new request: signedness and magnitudes.
    logic              in_signed;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic              div_by_zero;
    logic              sgn_ovf;

    assign in_signed   = (op_i == DIV) || (op_i == REM);
    assign a_abs       = (in_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
    assign b_abs       = (in_signed && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
    assign div_by_zero = (divisor_i == '0);
    assign sgn_ovf     = in_signed && (dividend_i == MIN_NEG) && (divisor_i == ALL_ONES);

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try a one-bit-wider subtract so a carried-out MSB is kept.
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic              fits;

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fits    = ~diff[XLEN];

    // Sign fix-up of the unsigned quotient/remainder.
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    assign quo_fix = (sgn_q && qneg_q) ? -quo_q : quo_q;
    assign rem_fix = (sgn_q && rneg_q) ? -rem_q : rem_q;

    // Next-state and datapath update; flush wins over every other request.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sgn_d    = sgn_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (start_i) begin
                        op_d   = div_op_e'(op_i);
                        sgn_d  = in_signed;
                        qneg_d = dividend_i[XLEN-1] ^ divisor_i[XLEN-1];
                        rneg_d = dividend_i[XLEN-1];
                        dvs_d  = b_abs;
                        rem_d  = '0;
                        quo_d  = a_abs;
                        cnt_d  = CNT_INIT;
                        if (div_by_zero) begin
                            state_d  = DONE;
                            result_d = ((op_i == DIV) || (op_i == DIVU)) ? ALL_ONES : dividend_i;
                        end else if (sgn_ovf) begin
                            state_d  = DONE;
                            result_d = (op_i == DIV) ? MIN_NEG : '0;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    if (fits) begin
                        rem_d = diff[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    result_d = ((op_q == DIV) || (op_q == DIVU)) ? quo_fix : rem_fix;
                    state_d  = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= DIV;
            sgn_q    <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sgn_q    <= sgn_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == CALC) || (state_q == FIX);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_rv32_e_div_seq.sv
// Scoreboard bench for rv32_e_div_seq: directed cases, control corner cases
// and a short randomized sweep against a behavioural division model.
module tb_rv32_e_div_seq;

    localparam logic [1:0] T_DIV  = 2'd0;
    localparam logic [1:0] T_DIVU = 2'd1;
    localparam logic [1:0] T_REM  = 2'd2;
    localparam logic [1:0] T_REMU = 2'd3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        flush_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    rv32_e_div_seq dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .flush_i    (flush_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          t_start = 0;
    logic [31:0] last_res = '0;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb_v;
        logic               ovf;
        sa   = a;
        sb_v = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            T_DIV:   model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb_v);
            T_DIVU:  model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            T_REM:   model = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb_v);
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ||
               (((op == T_DIV) || (op == T_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request so it is sampled at the next edge; leaves time at edge+1.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit   sp;
        sp    = is_special(op, a, b);
        e.res = model(op, a, b);
        e.lat = sp ? 1 : 34;
        sb.push_back(e);
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        t_start = cyc;
        check("busy_after_start", {31'b0, busy_o}, sp ? 32'd0 : 32'd1);
    endtask

    // Wait (bounded) for done_o, then pop the scoreboard and compare.
    task automatic wait_done(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!done_o && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        if (!done_o) begin
            check({tag, "_timeout"}, {31'b0, done_o}, 32'd1);
            return;
        end
        check({tag, "_result"}, result_o, e.res);
        check({tag, "_latency"}, 32'(cyc - t_start + 1), 32'(e.lat));
        last_res = result_o;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            5:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_i      = 1'b1;
        start_i    = 1'b0;
        flush_i    = 1'b0;
        op_i       = T_DIV;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   {31'b0, busy_o}, 32'd0);
        check("rst_done",   {31'b0, done_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Directed arithmetic cases.
        start_op(T_DIV,  32'd100, 32'd7);             wait_done("div_100_7");
        start_op(T_REM,  32'd100, 32'd7);             wait_done("rem_100_7");
        start_op(T_DIVU, 32'hFFFF_FFFF, 32'd2);       wait_done("divu_max_2");
        start_op(T_DIV,  -32'd100, 32'd7);            wait_done("div_m100_7");
        start_op(T_REM,  -32'd100, 32'd7);            wait_done("rem_m100_7");
        start_op(T_REM,  32'd100, -32'd7);            wait_done("rem_100_m7");
        start_op(T_DIVU, 32'd5, 32'd0);               wait_done("divu_5_0");
        start_op(T_REMU, 32'd5, 32'd0);               wait_done("remu_5_0");
        start_op(T_DIV,  -32'd5, 32'd0);              wait_done("div_m5_0");
        start_op(T_DIV,  32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_ovf");
        start_op(T_REM,  32'h8000_0000, 32'hFFFF_FFFF); wait_done("rem_ovf");
        check("ovf_busy_after", {31'b0, busy_o}, 32'd0);

        // Back-to-back: second request accepted in the DONE cycle.
        start_op(T_DIVU, 32'd1000, 32'd10);
        wait_done("b2b_first");
        start_op(T_REM, -32'd17, 32'd5);
        wait_done("b2b_second");

        // start_i held high during CALC with different operands: no restart.
        @(posedge clk);
        #1;
        start_op(T_DIV, 32'd100, 32'd7);
        start_i    = 1'b1;
        op_i       = T_DIVU;
        dividend_i = 32'd1;
        divisor_i  = 32'd1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        wait_done("held_start");

        // Flush at k+10: idle at k+11, no done, result unchanged.
        @(posedge clk);
        #1;
        start_op(T_DIV, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        void'(sb.pop_back());
        check("flush_busy",   {31'b0, busy_o}, 32'd0);
        check("flush_done",   {31'b0, done_o}, 32'd0);
        check("flush_result", result_o, last_res);
        start_op(T_DIVU, 32'd9, 32'd3);
        wait_done("after_flush");

        // Asynchronous reset mid-CALC.
        @(posedge clk);
        #1;
        start_op(T_DIVU, 32'd12345, 32'd7);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_busy",   {31'b0, busy_o}, 32'd0);
        check("arst_done",   {31'b0, done_o}, 32'd0);
        check("arst_result", result_o, 32'd0);
        #1;
        rst_i = 1'b0;
        void'(sb.pop_back());
        last_res = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("arst_no_done", {31'b0, done_o}, 32'd0);
        end

        // Randomized sweep over all four ops including corner operands.
        for (int op = 0; op < 4; op++) begin
            for (int i = 0; i < 120; i++) begin
                start_op(2'(op), pick(), pick());
                wait_done("random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global bound so a stuck DUT can never hang the run.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
